decomp_fetch_ctrl: RTL and testbench

- Parametrised successor of the decompressor control unit in decompressor_sys.
- Sits between instruction memory and the CPU and buffers up to DEPTH fetched words.
- Each word holds either one full instruction or up to PACK compressed instructions.
- Issues one instruction slot per CPU handshake and drives slot/table-select controls to the expansion datapath; handles branch redirect and flush, including discard of an in-flight fetch.

---
 rtl/decomp_pkg.sv | 15 +
 rtl/decomp_buf.sv | 48 ++++
 rtl/decomp_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_decomp_fetch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decomp_pkg.sv
// Shared types and helpers for the decompressor fetch controller.
package decomp_pkg;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_DROP
  } fetch_state_e;

  // Address step between consecutive fetch words.
  function automatic int word_bytes(input int word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/decomp_buf.sv
// Synchronous FIFO of fetched entries with flush, occupancy and head output.
module decomp_buf #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic [OCC_W-1:0]  occ,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // NOTE: storage is not reset; only pointers and occupancy qualify its contents.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !push) occ <= occ - OCC_W'(1);
    end
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (occ == '0);

endmodule

// File: rtl/decomp_fetch_ctrl.sv
// Fetch/issue controller between instruction memory and the CPU.
// Define DECOMP_PERF_EN to build the saturating consume counters.
module decomp_fetch_ctrl
  import decomp_pkg::*;
#(
  parameter int               ADDR_W     = 32,
  parameter int               WORD_W     = 32,
  parameter int               DEPTH      = 4,
  parameter int               PACK       = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  localparam int              CNT_W      = $clog2(PACK + 1),
  localparam int              SLOT_W     = $clog2(PACK)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_valid,
  input  logic [WORD_W-1:0] fetch_word,
  input  logic              fetch_encode,
  input  logic [CNT_W-1:0]  fetch_count,
  input  logic              cpu_req,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_word,
  output logic              out_encode,
  output logic [SLOT_W-1:0] out_slot,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_compressed
);

  localparam int               OCC_W    = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(word_bytes(WORD_W));
  localparam logic [OCC_W-1:0]  FULL_OCC = OCC_W'(DEPTH);

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              encode;
    logic [CNT_W-1:0]  count;
  } entry_t;

  fetch_state_e      state, state_nx;
  logic              run;
  logic [SLOT_W-1:0] slot;
  logic [OCC_W-1:0]  occ;
  logic              empty;
  entry_t            head;
  entry_t            push_entry;
  logic              push, pop, consume, more_slots, space;
  logic [CNT_W:0]    slot_ext;

  decomp_buf #(.DEPTH(DEPTH), .DATA_W($bits(entry_t))) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (branch),
    .push_data (push_entry),
    .head_data (head),
    .occ       (occ),
    .empty     (empty)
  );

  assign push_entry = '{word: fetch_word, encode: fetch_encode, count: fetch_count};

  // Requests only leave F_IDLE, where nothing is outstanding, so occupancy alone decides.
  assign space = run && (occ < FULL_OCC);

  // run holds requests off until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= F_IDLE;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      F_IDLE:  if (space && !branch) state_nx = F_WAIT;
      F_WAIT:  if (fetch_valid)      state_nx = F_IDLE;
               else if (branch)    state_nx = F_DROP;
      F_DROP:  if (fetch_valid)      state_nx = F_IDLE;
      default:                       state_nx = F_IDLE;
    endcase
  end

  always_comb begin
    fetch_req = 1'b0;
    push      = 1'b0;
    case (state)
      F_IDLE:  fetch_req = space && !branch;
      F_WAIT:  push      = fetch_valid && !branch;
      default: ;
    endcase
  end

  assign out_valid  = !empty;
  assign out_word   = out_valid ? head.word : '0;
  assign out_encode = out_valid && head.encode;
  assign out_slot   = slot;

  assign consume    = out_valid && cpu_req && !branch;
  assign slot_ext   = {{(CNT_W + 1 - SLOT_W){1'b0}}, slot} + (CNT_W + 1)'(1);
  assign more_slots = head.encode && (slot_ext < {1'b0, head.count});
  assign pop        = consume && !more_slots;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_addr <= RESET_ADDR;
      slot       <= '0;
    end else begin
      if (branch)         fetch_addr <= branch_addr;
      else if (fetch_req) fetch_addr <= fetch_addr + ADDR_INC;

      if (branch)       slot <= '0;
      else if (consume) slot <= more_slots ? slot + SLOT_W'(1) : '0;
    end
  end

`ifdef DECOMP_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issued     <= '0;
      perf_compressed <= '0;
    end else if (consume) begin
      if (perf_issued != '1)                   perf_issued     <= perf_issued + 32'd1;
      if (out_encode && perf_compressed != '1) perf_compressed <= perf_compressed + 32'd1;
    end
  end
`else
  assign perf_issued     = '0;
  assign perf_compressed = '0;
`endif

endmodule

// File: tb/tb_decomp_fetch_ctrl.sv
// Scoreboard bench for decomp_fetch_ctrl: a latency-configurable memory model feeds
// expected issue slots into a queue that is compared against the presented head.
module tb_decomp_fetch_ctrl;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;
  localparam int PACK   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [WORD_W-1:0] fetch_word;
  logic              fetch_encode;
  logic [2:0]        fetch_count;
  logic              cpu_req;
  logic              branch;
  logic [ADDR_W-1:0] branch_addr;
  logic              out_valid;
  logic [WORD_W-1:0] out_word;
  logic              out_encode;
  logic [1:0]        out_slot;
  logic [31:0]       perf_issued;
  logic [31:0]       perf_compressed;

  decomp_fetch_ctrl #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .PACK(PACK), .RESET_ADDR('0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_valid     (fetch_valid),
    .fetch_word      (fetch_word),
    .fetch_encode    (fetch_encode),
    .fetch_count     (fetch_count),
    .cpu_req         (cpu_req),
    .branch          (branch),
    .branch_addr     (branch_addr),
    .out_valid       (out_valid),
    .out_word        (out_word),
    .out_encode      (out_encode),
    .out_slot        (out_slot),
    .perf_issued     (perf_issued),
    .perf_compressed (perf_compressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        enc;
    logic [1:0]  slot;
  } item_t;

  item_t       sb[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // memory / stimulus model state
  int          mode, mem_lat, mem_cnt;
  logic        mem_busy, mem_killed, mem_stale;
  logic [31:0] mem_addr, exp_addr;
  logic [31:0] rsp_word;
  logic        rsp_enc;
  logic [2:0]  rsp_cnt;
  logic        prev_out_valid, prev_fetch_req;
  logic [31:0] prev_fetch_addr;
  logic        drv_cpu_req, drv_branch;
  logic [31:0] drv_branch_addr;
  logic        branch_on_valid, bov_hit, bov_pending, inject_stale;
  logic [31:0] bov_addr;
  logic        capture_next;
  logic [31:0] captured_addr;
  int          n_req, n_consumed, n_comp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void mem_read(input logic [31:0] a, output logic [31:0] w,
                                   output logic e, output logic [2:0] c);
    if (mode == 0) begin
      w = 32'h13 | {a[23:0], 8'h00};
      e = 1'b0;
      c = 3'($urandom_range(1, 4));
    end else begin
      w = 32'hABCD1234 ^ a;
      e = 1'b1;
      c = 3'(mode + 1);
    end
  endfunction

  task automatic push_rsp();
    item_t it;
    it.word = rsp_word;
    it.enc  = rsp_enc;
    if (rsp_enc) begin
      for (int i = 0; i < int'(rsp_cnt); i++) begin
        it.slot = 2'(i);
        sb.push_back(it);
      end
    end else begin
      it.slot = 2'd0;
      sb.push_back(it);
    end
  endtask

  task automatic sample();
    prev_out_valid  = out_valid;
    prev_fetch_req  = fetch_req;
    prev_fetch_addr = fetch_addr;
    if (fetch_req) begin
      check("fetch_addr", fetch_addr, exp_addr);
      exp_addr += 32'd4;
      n_req++;
      if (capture_next) begin
        captured_addr = fetch_addr;
        capture_next  = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic due;
    @(negedge clk);
    // account for what the DUT saw at the last rising edge
    if (branch) begin
      sb.delete();
      mem_killed = 1'b1;
      exp_addr   = branch_addr;
    end else if (prev_out_valid && cpu_req && sb.size() != 0) begin
      if (sb[0].enc) n_comp++;
      n_consumed++;
      void'(sb.pop_front());
    end
    if (fetch_valid) begin
      if (mem_busy && !mem_stale && !mem_killed && !branch) push_rsp();
      mem_busy  = 1'b0;
      mem_stale = 1'b0;
    end
    if (prev_fetch_req) begin
      mem_busy   = 1'b1;
      mem_killed = 1'b0;
      mem_cnt    = mem_lat;
      mem_addr   = prev_fetch_addr;
    end

    check("out_valid", out_valid, sb.size() != 0);
    if (out_valid && sb.size() != 0) begin
      check("out_word", out_word, sb[0].word);
      check("out_encode", out_encode, sb[0].enc);
      check("out_slot", out_slot, sb[0].slot);
    end

    fetch_valid = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_read(mem_addr, rsp_word, rsp_enc, rsp_cnt);
        fetch_valid  = 1'b1;
        fetch_word   = rsp_word;
        fetch_encode = rsp_enc;
        fetch_count  = rsp_cnt;
      end
    end
    cpu_req     = drv_cpu_req;
    branch      = drv_branch;
    branch_addr = drv_branch_addr;
    drv_branch  = 1'b0;
    due         = bov_pending;
    bov_pending = 1'b0;
    if (branch_on_valid && fetch_valid) begin
      branch          = 1'b1;
      branch_addr     = bov_addr;
      branch_on_valid = 1'b0;
      bov_hit         = 1'b1;
      bov_pending     = 1'b1;
    end
    if (branch) capture_next = 1'b1;

    #1;
    if (due) check("redirect_req", fetch_req, 1'b1);
    sample();
  endtask

  task automatic check_perf(input string tag);
`ifdef DECOMP_PERF_EN
    check({tag, "_perf_issued"}, perf_issued, 64'(n_consumed));
    check({tag, "_perf_compressed"}, perf_compressed, 64'(n_comp));
`else
    check({tag, "_perf_issued"}, perf_issued, 64'd0);
    check({tag, "_perf_compressed"}, perf_compressed, 64'd0);
`endif
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_fetch_req"}, fetch_req, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_word"}, out_word, 64'd0);
    check({tag, "_out_encode"}, out_encode, 1'b0);
    check({tag, "_out_slot"}, out_slot, 64'd0);
    check({tag, "_fetch_addr"}, fetch_addr, 64'd0);
    check({tag, "_perf_issued"}, perf_issued, 64'd0);
    check({tag, "_perf_compressed"}, perf_compressed, 64'd0);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    cpu_req     = 1'b0;
    branch      = 1'b0;
    branch_addr = '0;
    fetch_word  = '0;
    fetch_encode = 1'b0;
    fetch_count = '0;
    if (!inject_stale) fetch_valid = 1'b0;
    sb.delete();
    mem_busy = 1'b0; mem_killed = 1'b0; mem_stale = 1'b0; mem_cnt = 0;
    exp_addr = '0; n_req = 0; n_consumed = 0; n_comp = 0;
    prev_out_valid = 1'b0; prev_fetch_req = 1'b0; prev_fetch_addr = '0;
    drv_cpu_req = 1'b0; drv_branch = 1'b0; drv_branch_addr = '0;
    branch_on_valid = 1'b0; bov_hit = 1'b0; bov_pending = 1'b0;
    capture_next = 1'b0; captured_addr = '0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    reset = 1'b1;
    if (inject_stale) begin
      // a response with no request behind it, arriving while the FSM idles
      fetch_valid  = 1'b1;
      fetch_word   = 32'hDEADBEEF;
      fetch_encode = 1'b0;
      mem_stale    = 1'b1;
      inject_stale = 1'b0;
    end
    #1;
    sample();
  endtask

  initial begin
    inject_stale = 1'b0;
    fetch_valid  = 1'b0;

    // uncompressed stream, 1-cycle memory, CPU always ready
    do_reset();
    mode = 0; mem_lat = 1; drv_cpu_req = 1'b1;
    repeat (24) tick();
    check("A_req_count", n_req >= 6, 1'b1);
    check_perf("A");

    // two-slot compressed words
    do_reset();
    mode = 1; mem_lat = 1; drv_cpu_req = 1'b1;
    repeat (24) tick();
    check("B_comp_seen", n_comp >= 2, 1'b1);
    check_perf("B");

    // three-slot and full four-slot packs
    do_reset();
    mode = 2; mem_lat = 2; drv_cpu_req = 1'b1;
    repeat (20) tick();
    mode = 3;
    repeat (30) tick();
    check_perf("C");

    // CPU stalled: buffer fills, then one consume frees one request
    do_reset();
    mode = 0; mem_lat = 1; drv_cpu_req = 1'b0;
    repeat (20) tick();
    check("D_full_reqs", n_req, 64'd4);
    drv_cpu_req = 1'b1;
    tick();
    drv_cpu_req = 1'b0;
    repeat (20) tick();
    check("D_one_more_req", n_req, 64'd5);
    check_perf("D");

    // branch while a fetch is outstanding; response lands in F_DROP
    do_reset();
    mode = 0; mem_lat = 3; drv_cpu_req = 1'b1;
    for (int i = 0; i < 10 && !prev_fetch_req; i++) tick();
    check("E_first_req", prev_fetch_req, 1'b1);
    drv_branch = 1'b1; drv_branch_addr = 32'h100;
    tick();
    repeat (20) tick();
    check("E_branch_target", captured_addr, 64'h100);
    check_perf("E");

    // branch together with fetch_valid and cpu_req on a busy buffer
    do_reset();
    mode = 3; mem_lat = 2; drv_cpu_req = 1'b1;
    repeat (12) tick();
    branch_on_valid = 1'b1; bov_addr = 32'h200;
    for (int i = 0; i < 20 && !bov_hit; i++) tick();
    check("F_branch_hit", bov_hit, 1'b1);
    repeat (20) tick();
    check("F_branch_target", captured_addr, 64'h200);
    check_perf("F");

    // async reset in the middle of F_WAIT, then a stray response after release
    do_reset();
    mode = 0; mem_lat = 4; drv_cpu_req = 1'b0;
    for (int i = 0; i < 40 && !(sb.size() != 0 && mem_busy && mem_cnt >= 2); i++) tick();
    check("G_wait_reached", sb.size() != 0 && mem_busy && mem_cnt >= 2, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_reset("async");
    inject_stale = 1'b1;
    do_reset();
    mode = 0; mem_lat = 1; drv_cpu_req = 1'b1;
    repeat (16) tick();
    check("G_reqs_after", n_req >= 3, 1'b1);
    check_perf("G");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
